uart_rx_core: RTL and testbench

//  Serial receiver paired with the TX path: recovers 8-bit frames from the serial line driven by TX data_tx.

---
 rtl/uart_rx_core.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled UART receiver, 8N1 / 8O1 / 8E1 frames.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting per bit.
module uart_rx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int DIV0 = CLK_FREQ / (2400 * OVERSAMPLE);
    localparam int DIV1 = CLK_FREQ / (4800 * OVERSAMPLE);
    localparam int DIV2 = CLK_FREQ / (9600 * OVERSAMPLE);
    localparam int DIV3 = CLK_FREQ / (19200 * OVERSAMPLE);
    localparam int CW   = $clog2(DIV0 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          line_prev;
    logic [CW-1:0] div_sel;
    logic [CW-1:0] div_q;
    logic [CW-1:0] bcnt;
    logic          tick;
    logic          start_det;
    logic [3:0]    tcnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          par_en;
    logic          par_odd;
    logic          par_err;
    logic          bit_val;
    logic          start_pt;
    logic          samp_now;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= data_rx;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign start_det = (state == S_IDLE) && line_prev && !sync2;

    always_comb begin
        div_sel = CW'(DIV0);
        unique case (baud_rate)
            2'b00: div_sel = CW'(DIV0);
            2'b01: div_sel = CW'(DIV1);
            2'b10: div_sel = CW'(DIV2);
            2'b11: div_sel = CW'(DIV3);
            default: div_sel = CW'(DIV0);
        endcase
    end

    assign tick = (bcnt == div_q - CW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcnt <= '0;
        end else if (start_det || tick) begin
            bcnt <= '0;
        end else begin
            bcnt <= bcnt + CW'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s7;
    logic s8;

    // tcnt is never re-aligned here; every bit is voted at 7,8,9.
    assign samp_now = tick && (tcnt == 4'd9);
    assign start_pt = samp_now;
    assign bit_val  = (s7 & s8) | (s7 & sync2) | (s8 & sync2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick) begin
            if (tcnt == 4'd7) s7 <= sync2;
            if (tcnt == 4'd8) s8 <= sync2;
        end
    end
`else
    assign start_pt = tick && (tcnt == 4'd7);
    assign samp_now = tick && (tcnt == 4'd15);
    assign bit_val  = sync2;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            tcnt         <= '0;
            shreg        <= '0;
            bit_idx      <= '0;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            par_err      <= 1'b0;
            div_q        <= CW'(DIV0);
            data_out     <= '0;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b1;
        end else begin
            valid <= 1'b0;
            if (tick && state != S_IDLE) tcnt <= tcnt + 4'd1;
            unique case (state)
                S_IDLE: begin
                    if (start_det) begin
                        state       <= S_START;
                        tcnt        <= '0;
                        bit_idx     <= '0;
                        div_q       <= div_sel;
                        par_en      <= (parity_type == 2'b01) ||
                                       (parity_type == 2'b10);
                        par_odd     <= (parity_type == 2'b01);
                        par_err     <= 1'b0;
                        active_flag <= 1'b1;
                        done_flag   <= 1'b0;
                    end
                end
                S_START: begin
                    if (start_pt) begin
                        if (bit_val) begin
                            state       <= S_IDLE;
                            active_flag <= 1'b0;
                            done_flag   <= 1'b1;
                        end else begin
                            state <= S_DATA;
`ifndef UART_RX_MAJORITY_EN
                            tcnt  <= '0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (samp_now) begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (samp_now) begin
                        par_err <= par_odd ? ~^{bit_val, shreg}
                                           :  ^{bit_val, shreg};
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (samp_now) begin
                        data_out     <= shreg;
                        valid        <= 1'b1;
                        parity_error <= par_en & par_err;
                        frame_error  <= ~bit_val;
                        active_flag  <= 1'b0;
                        done_flag    <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frames checked against a frame-level model.
module tb_uart_rx_core;

    localparam int CLK_FREQ = 1_300_000;

    logic       clock;
    logic       reset_n;
    logic       data_rx;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_error;
    logic       frame_error;
    logic       active_flag;
    logic       done_flag;

    int checks = 0;
    int errors = 0;

    logic [9:0] rx_q[$];
    logic       prev_valid = 1'b0;
    bit         dbl_valid  = 1'b0;

    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .data_rx(data_rx),
        .baud_rate(baud_rate),
        .parity_type(parity_type),
        .data_out(data_out),
        .valid(valid),
        .parity_error(parity_error),
        .frame_error(frame_error),
        .active_flag(active_flag),
        .done_flag(done_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (valid === 1'b1) begin
            rx_q.push_back({parity_error, frame_error, data_out});
            if (prev_valid === 1'b1) dbl_valid = 1'b1;
        end
        prev_valid = valid;
    end

    function automatic int bit_cycles(input logic [1:0] br);
        int baud;
        baud = 2400 << br;
        return 16 * (CLK_FREQ / (baud * 16));
    endfunction

    // Expected record {parity_error, frame_error, byte} for one frame.
    function automatic logic [9:0] model(input logic [7:0] d,
                                         input logic [1:0] pt,
                                         input bit flip,
                                         input bit stop_v);
        bit pen;
        pen = (pt == 2'b01) || (pt == 2'b10);
        return {pen && flip, !stop_v, d};
    endfunction

    task automatic idle_cycles(input int n);
        data_rx = 1'b1;
        repeat (n) @(posedge clock);
    endtask

    // Line is left at the stop value when the task returns.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] br,
                              input logic [1:0] pt, input bit flip,
                              input bit stop_v, input bit cfg_chg);
        int  bc;
        bit  pen;
        logic p;
        bc  = bit_cycles(br);
        pen = (pt == 2'b01) || (pt == 2'b10);
        p   = (pt == 2'b01) ? ~^d : ^d;
        p   = p ^ flip;
        baud_rate   = br;
        parity_type = pt;
        @(posedge clock);
        data_rx = 1'b0;
        repeat (bc / 2) @(posedge clock);
        #1;
        checks++;
        if (active_flag !== 1'b1 || done_flag !== 1'b0) begin
            errors++;
            $display("FAIL busy_flags active=%b done=%b exp active=1 done=0",
                     active_flag, done_flag);
        end
        if (cfg_chg) begin
            baud_rate   = 2'($urandom);
            parity_type = 2'($urandom);
        end
        repeat (bc - bc / 2) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            data_rx = d[i];
            repeat (bc) @(posedge clock);
        end
        if (pen) begin
            data_rx = p;
            repeat (bc) @(posedge clock);
        end
        data_rx = stop_v;
        repeat (bc) @(posedge clock);
    endtask

    task automatic get_rx(output bit got, output logic [9:0] w);
        if (rx_q.size() > 0) begin
            got = 1'b1;
            w   = rx_q.pop_front();
        end else begin
            got = 1'b0;
            w   = 'x;
        end
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        data_rx     = 1'b1;
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if ({data_out, valid, parity_error, frame_error, active_flag,
             done_flag} !== {8'h00, 5'b00001}) begin
            errors++;
            $display("FAIL reset_vals got=%h/%b%b%b%b%b exp=00/00001",
                     data_out, valid, parity_error, frame_error,
                     active_flag, done_flag);
        end
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (rx_q.size() != 0 || done_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle pulses=%0d done=%b exp 0 and 1",
                     rx_q.size(), done_flag);
        end
    endtask

    task automatic test_basic;
        bit got;
        logic [9:0] w;
        send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        idle_cycles(bit_cycles(2'b10));
        get_rx(got, w);
        checks++;
        if ({got, w} !== {1'b1, model(8'hA5, 2'b00, 1'b0, 1'b1)}) begin
            errors++;
            $display("FAIL basic_A5 got=%b/%h exp=1/%h", got, w,
                     model(8'hA5, 2'b00, 1'b0, 1'b1));
        end
        #1;
        checks++;
        if (done_flag !== 1'b1 || active_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b active=%b exp 1 0",
                     done_flag, active_flag);
        end
    endtask

    task automatic test_odd_parity;
        bit got;
        logic [9:0] w;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h3C, 2'b10, 2'b01, k[0], 1'b1, 1'b0);
            idle_cycles(bit_cycles(2'b10));
            get_rx(got, w);
            checks++;
            if ({got, w} !== {1'b1, model(8'h3C, 2'b01, k[0], 1'b1)}) begin
                errors++;
                $display("FAIL odd_par_%0d got=%b/%h exp=1/%h", k, got, w,
                         model(8'h3C, 2'b01, k[0], 1'b1));
            end
        end
    endtask

    task automatic test_frame_error;
        bit got;
        logic [9:0] w;
        int bc;
        bc = bit_cycles(2'b10);
        send_frame(8'h81, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        repeat (3 * bc) @(posedge clock);
        #1;
        checks++;
        if (done_flag !== 1'b1 || active_flag !== 1'b0 || rx_q.size() != 1) begin
            errors++;
            $display("FAIL stuck_low done=%b active=%b pulses=%0d exp 1 0 1",
                     done_flag, active_flag, rx_q.size());
        end
        get_rx(got, w);
        checks++;
        if ({got, w} !== {1'b1, model(8'h81, 2'b10, 1'b0, 1'b0)}) begin
            errors++;
            $display("FAIL frame_err got=%b/%h exp=1/%h", got, w,
                     model(8'h81, 2'b10, 1'b0, 1'b0));
        end
        idle_cycles(bc);
        send_frame(8'h00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0);
        idle_cycles(bc);
        get_rx(got, w);
        checks++;
        if ({got, w} !== {1'b1, model(8'h00, 2'b10, 1'b0, 1'b1)}) begin
            errors++;
            $display("FAIL frame_clr got=%b/%h exp=1/%h", got, w,
                     model(8'h00, 2'b10, 1'b0, 1'b1));
        end
    endtask

    task automatic test_glitch;
        int dv;
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        dv = bit_cycles(2'b10) / 16;
        @(posedge clock);
        data_rx = 1'b0;
        repeat (3 * dv) @(posedge clock);
        #1;
        checks++;
        if (active_flag !== 1'b1 || done_flag !== 1'b0) begin
            errors++;
            $display("FAIL glitch_start active=%b done=%b exp 1 0",
                     active_flag, done_flag);
        end
        repeat (dv) @(posedge clock);
        data_rx = 1'b1;
        repeat (10 * dv) @(posedge clock);
        #1;
        checks++;
        if (active_flag !== 1'b0 || done_flag !== 1'b1 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_idle active=%b done=%b pulses=%0d exp 0 1 0",
                     active_flag, done_flag, rx_q.size());
        end
        idle_cycles(2 * bit_cycles(2'b10));
    endtask

    task automatic test_back_to_back;
        bit got;
        logic [9:0] w;
        logic [7:0] bytes [2];
        bytes[0] = 8'h55;
        bytes[1] = 8'hFF;
        send_frame(bytes[0], 2'b11, 2'b10, 1'b0, 1'b1, 1'b0);
        send_frame(bytes[1], 2'b11, 2'b10, 1'b0, 1'b1, 1'b0);
        idle_cycles(bit_cycles(2'b11));
        for (int k = 0; k < 2; k++) begin
            get_rx(got, w);
            checks++;
            if ({got, w} !== {1'b1, model(bytes[k], 2'b10, 1'b0, 1'b1)}) begin
                errors++;
                $display("FAIL b2b_%0d got=%b/%h exp=1/%h", k, got, w,
                         model(bytes[k], 2'b10, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit got;
        logic [9:0] w;
        logic [7:0] d;
        int bc;
        d  = 8'h5A;
        bc = bit_cycles(2'b10);
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        @(posedge clock);
        data_rx = 1'b0;
        repeat (bc) @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            data_rx = d[i];
            repeat (bc) @(posedge clock);
        end
        data_rx = d[4];
        repeat (bc / 2) @(posedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data_out, valid, parity_error, frame_error, active_flag,
             done_flag} !== {8'h00, 5'b00001}) begin
            errors++;
            $display("FAIL mid_reset got=%h/%b%b%b%b%b exp=00/00001",
                     data_out, valid, parity_error, frame_error,
                     active_flag, done_flag);
        end
        data_rx = 1'b1;
        repeat (3) @(posedge clock);
        reset_n = 1'b1;
        idle_cycles(2 * bc);
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pulse got=%0d exp=0", rx_q.size());
        end
        send_frame(8'h7E, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        idle_cycles(bc);
        get_rx(got, w);
        checks++;
        if ({got, w} !== {1'b1, model(8'h7E, 2'b00, 1'b0, 1'b1)}) begin
            errors++;
            $display("FAIL post_reset got=%b/%h exp=1/%h", got, w,
                     model(8'h7E, 2'b00, 1'b0, 1'b1));
        end
    endtask

    task automatic test_random;
        bit got;
        logic [9:0] w;
        logic [9:0] exp;
        logic [7:0] d;
        logic [1:0] br;
        logic [1:0] pt;
        bit flip;
        bit stop_v;
        bit chg;
        for (int n = 0; n < 10; n++) begin
            d      = 8'($urandom);
            br     = 2'($urandom_range(0, 3));
            pt     = 2'($urandom);
            flip   = 1'($urandom_range(0, 1));
            stop_v = ($urandom_range(0, 3) != 0);
            chg    = 1'($urandom_range(0, 1));
            exp    = model(d, pt, flip, stop_v);
            send_frame(d, br, pt, flip, stop_v, chg);
            idle_cycles(bit_cycles(br));
            get_rx(got, w);
            checks++;
            if ({got, w} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL rand_%0d br=%0d pt=%0d got=%b/%h exp=1/%h",
                         n, br, pt, got, w, exp);
            end
        end
        checks++;
        if (dbl_valid || rx_q.size() != 0) begin
            errors++;
            $display("FAIL valid_pulse wide=%b extra=%0d exp 0 0",
                     dbl_valid, rx_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_odd_parity;
        test_frame_error;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
